// File: rtl/mdu_iter_if.sv
// mdu_iter_if: operand/control/result bundle between the multicycle MIPS
// controller (master) and the iterative multiply/divide unit (slave).
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, followed by a single sign-fixup cycle. MTHI/MTLO writes are accepted
// only while the unit is not busy.
// Build option MDU_FAST_MUL_EN: multiplies finish in one cycle (E0 writes the
// full product and jumps to DONE); divide timing is unchanged.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic             is_div;
    logic             sa, sb;
    logic             b_zero;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] op_m;     // multiplicand (MUL) or divisor (DIV) magnitude
    logic [WIDTH-1:0] acc_hi;   // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier shifting out / quotient shifting in
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             start_ok;
    logic             in_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             last_iter;

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

    // Operand magnitudes, per-iteration step values and sign-fixed results
    always_comb begin
        start_ok  = (state == S_IDLE) && bus.start;
        in_signed = ~bus.op[0];
        a_mag     = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag     = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_m} : '0);
        rem_sh    = {acc_hi, acc_lo[WIDTH-1]};
        rem_diff  = rem_sh - {1'b0, op_m};
        prod_mag  = {acc_hi, acc_lo};
        prod_fix  = (sa ^ sb) ? -prod_mag : prod_mag;
        q_fix     = (sa ^ sb) ? -acc_lo : acc_lo;
        r_fix     = sa ? -acc_hi : acc_hi;
        last_iter = (cnt == CW'(WIDTH - 1));
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;

    // Full-width single-cycle product; sign-extending both operands to 2*WIDTH gives the signed result
    always_comb begin
        fast_prod = bus.op[0]
            ? ({{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b})
            : ({{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b});
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic and busy/done decode
    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op[1]) state_nx = S_DIV;
`ifdef MDU_FAST_MUL_EN
                    else           state_nx = S_DONE;
`else
                    else           state_nx = S_MUL;
`endif
                end
            end
            S_MUL: begin
                bus.busy = 1'b1;
                if (last_iter) state_nx = S_FIX;
            end
            S_DIV: begin
                bus.busy = 1'b1;
                if (last_iter) state_nx = S_FIX;
            end
            S_FIX: begin
                bus.busy = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand latch at launch, then one shift-add or restoring-divide step per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
            op_m   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        is_div <= bus.op[1];
                        sa     <= in_signed & bus.a[WIDTH-1];
                        sb     <= in_signed & bus.b[WIDTH-1];
                        b_zero <= (bus.b == '0);
                        a_raw  <= bus.a;
                        op_m   <= bus.op[1] ? b_mag : a_mag;
                        acc_lo <= bus.op[1] ? a_mag : b_mag;
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                end
                S_DIV: begin
                    // Remainder is always below the divisor, so a set rem_sh[WIDTH] implies a non-negative difference
                    if (!rem_diff[WIDTH]) begin
                        acc_hi <= rem_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= rem_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // HI/LO: MT writes when not busy; op results (fixup cycle or fast multiply) take priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (state == S_IDLE || state == S_DONE) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
`ifdef MDU_FAST_MUL_EN
            if (start_ok && !bus.op[1]) {hi_q, lo_q} <= fast_prod;
`endif
            if (state == S_FIX) begin
                if (!is_div) begin
                    {hi_q, lo_q} <= prod_fix;
                end else if (b_zero) begin
                    hi_q <= a_raw;
                    lo_q <= '1;
                end else begin
                    hi_q <= r_fix;
                    lo_q <= q_fix;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against a plain
// arithmetic reference model (64-bit products, native signed divide).
module tb_mdu_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO results from plain arithmetic
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l);
        logic [63:0] p;
        int          q, r;
        h = '0;
        l = '0;
        case (op)
            2'b00: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                h = p[63:32];
                l = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            2'b10: begin
                if (b == '0) begin
                    l = '1;
                    h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = '0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    l = q;
                    h = r;
                end
            end
            default: begin
                if (b == '0) begin
                    l = '1;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endtask

    function automatic int exp_lat(input logic [1:0] op);
`ifdef MDU_FAST_MUL_EN
        if (!op[1]) return 1;
`endif
        return W + 2;
    endfunction

    // One complete operation; optional MTHI alongside start must be overwritten by the result
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic mt_with_start);
        logic [W-1:0] eh, el;
        int done_edge;
        int busy_cnt;
        model(op, a, b, eh, el);
        done_edge = 0;
        busy_cnt  = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.hi_we = mt_with_start;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
            end
            if (bus.done) begin
                done_edge = k;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        check({tag, "/done_edge"}, 64'(done_edge), 64'(exp_lat(op)));
        check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_lat(op) - 1));
        if (done_edge != 0) check({tag, "/busy_in_done"}, 64'(bus.busy), 64'(0));
        check({tag, "/hi"}, 64'(bus.hi), 64'(eh));
        check({tag, "/lo"}, 64'(bus.lo), 64'(el));
        exp_hi = eh;
        exp_lo = el;
        @(negedge clk);
        check({tag, "/done_width"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        logic [W-1:0] eh, el, ra, rb, wv;
        logic [1:0]   rop;
        int           done_edge;

        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        // Reset state
        #23;
        check("rst/hi", 64'(bus.hi), 64'(0));
        check("rst/lo", 64'(bus.lo), 64'(0));
        check("rst/busy", 64'(bus.busy), 64'(0));
        check("rst/done", 64'(bus.done), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 1'b1);
        run_op("div_by0_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);

        // MT write in IDLE
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_ABCD;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_idle/hi", 64'(bus.hi), 64'(32'h0000_ABCD));
        check("mthi_idle/lo", 64'(bus.lo), 64'(exp_lo));
        exp_hi = 32'h0000_ABCD;

        // MT write while busy and a re-pulsed start are both ignored
        model(2'b11, 32'd1000, 32'd7, eh, el);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd1000;
        bus.b     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.start = 1'b0;
        check("busy_mt/hi", 64'(bus.hi), 64'(exp_hi));
        check("busy_mt/busy", 64'(bus.busy), 64'(1));
        done_edge = 0;
        for (int k = 4; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_edge = k;
                break;
            end
        end
        check("restart_ignored/done_edge", 64'(done_edge), 64'(W + 2));
        check("restart_ignored/hi", 64'(bus.hi), 64'(eh));
        check("restart_ignored/lo", 64'(bus.lo), 64'(el));
        // MTLO in the DONE cycle
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_0055;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_done/lo", 64'(bus.lo), 64'(32'h0000_0055));
        check("mtlo_done/hi", 64'(bus.hi), 64'(eh));
        exp_hi = eh;
        exp_lo = 32'h0000_0055;

        // Reset part-way through a divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'd3;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("pre_rst/busy", 64'(bus.busy), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst/busy", 64'(bus.busy), 64'(0));
        check("mid_rst/hi", 64'(bus.hi), 64'(0));
        check("mid_rst/lo", 64'(bus.lo), 64'(0));
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        run_op("after_rst", 2'b10, 32'h1234_5678, 32'd3, 1'b0);

        // Randomized operations
        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                4: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'($urandom_range(0, 1)));
            // occasional MT write between operations
            if ($urandom_range(0, 2) == 0) begin
                wv = $urandom;
                @(negedge clk);
                bus.lo_we = 1'b1;
                bus.wdata = wv;
                @(negedge clk);
                bus.lo_we = 1'b0;
                check($sformatf("rand%0d_mtlo", i), 64'(bus.lo), 64'(wv));
                exp_lo = wv;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
